// File: rtl/vga_timing_rx.sv
// vga_timing_rx: receive side of the VGA timing interface.
// Registers the incoming sync/de/pixel stream, recovers X/Y coordinates,
// measures line and frame geometry and declares lock once two consecutive
// frames have identical geometry.
// Optional frame CRC output is enabled by defining VGA_RX_FRAME_CRC_EN.
module vga_timing_rx #(
    parameter int HSZ    = 10,
    parameter int VSZ    = 10,
    parameter bit HS_POL = 1'b0,
    parameter bit VS_POL = 1'b0
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            i_hsync,
    input  logic            i_vsync,
    input  logic            i_de,
    input  logic [11:0]     i_rgb,
    output logic            o_pix_valid,
    output logic [11:0]     o_pix,
    output logic [HSZ-1:0]  o_x,
    output logic [VSZ-1:0]  o_y,
    output logic            o_line_start,
    output logic            o_frame_start,
    output logic [HSZ-1:0]  o_h_total,
    output logic [HSZ-1:0]  o_h_active,
    output logic [VSZ-1:0]  o_v_total,
    output logic [VSZ-1:0]  o_v_active,
    output logic            o_locked
`ifdef VGA_RX_FRAME_CRC_EN
    ,
    output logic [15:0]     o_frame_crc
`endif
);

    typedef enum logic [1:0] {SEARCH, MEASURE, VERIFY, LOCKED} state_t;

    localparam logic [HSZ-1:0] H_ONE = HSZ'(1);
    localparam logic [HSZ-1:0] H_MAX = '1;
    localparam logic [VSZ-1:0] V_ONE = VSZ'(1);
    localparam logic [VSZ-1:0] V_MAX = '1;
    localparam int             GW    = 2 * HSZ + 2 * VSZ;

    logic hsAct1_q, hsAct2_q, vsAct1_q, vsAct2_q, de1_q, de2_q;
    logic [11:0] rgb1_q;
    logic hsLead, vsLead, deRise, deFall;

    logic            pixValid_q, lineStart_q, frameStart_q, yFirst_q;
    logic [11:0]     pix_q;
    logic [HSZ-1:0]  x_q;
    logic [VSZ-1:0]  y_q;

    logic [HSZ-1:0]  hCnt_q, hCnt_d, haCnt_q, haCnt_d, hFirst_q, hFirst_d;
    logic [HSZ-1:0]  hTot_q, hTot_d, hAct_q, hAct_d;
    logic [VSZ-1:0]  vCnt_q, vCnt_d, vaCnt_q, vaCnt_d, vLine, vaLine;
    logic [VSZ-1:0]  vTot_q, vTot_d, vAct_q, vAct_d;
    logic            lineDe_q, lineDe_d, hHave_q, hHave_d, hMis_q, hMis_d, lineMis;

    state_t          state_q, state_d;
    logic            snapLoad, snapMis_q, frameOk;
    logic [GW-1:0]   snap_q, geomNow;

    assign hsLead = hsAct1_q & ~hsAct2_q;
    assign vsLead = vsAct1_q & ~vsAct2_q;
    assign deRise = de1_q & ~de2_q;
    assign deFall = ~de1_q & de2_q;

    // Input register plus a second stage of the control bits for edge detection
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            hsAct1_q <= 1'b0; hsAct2_q <= 1'b0;
            vsAct1_q <= 1'b0; vsAct2_q <= 1'b0;
            de1_q    <= 1'b0; de2_q    <= 1'b0;
            rgb1_q   <= '0;
        end else begin
            hsAct1_q <= (i_hsync == HS_POL);
            hsAct2_q <= hsAct1_q;
            vsAct1_q <= (i_vsync == VS_POL);
            vsAct2_q <= vsAct1_q;
            de1_q    <= i_de;
            de2_q    <= de1_q;
            rgb1_q   <= i_rgb;
        end
    end

    // Pixel path: registered pixel, sync pulses and saturating X/Y coordinates
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pixValid_q   <= 1'b0;
            pix_q        <= '0;
            lineStart_q  <= 1'b0;
            frameStart_q <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            yFirst_q     <= 1'b0;
        end else begin
            pixValid_q   <= de1_q;
            pix_q        <= rgb1_q;
            lineStart_q  <= hsLead;
            frameStart_q <= vsLead;
            if (deRise) begin
                x_q <= '0;
            end else if (de1_q && x_q != H_MAX) begin
                x_q <= x_q + H_ONE;
            end
            if (deRise && yFirst_q) begin
                y_q      <= '0;
                yFirst_q <= 1'b0;
            end else if (deFall && y_q != V_MAX) begin
                y_q <= y_q + V_ONE;
            end
            if (vsLead) begin
                yFirst_q <= 1'b1;
            end
        end
    end

    // Measurement next state: line processing first, then frame processing
    always_comb begin
        hCnt_d   = (hCnt_q == H_MAX) ? hCnt_q : hCnt_q + H_ONE;
        haCnt_d  = (de1_q && haCnt_q != H_MAX) ? haCnt_q + H_ONE : haCnt_q;
        lineDe_d = lineDe_q | de1_q;
        hFirst_d = hFirst_q;
        hHave_d  = hHave_q;
        hMis_d   = hMis_q;
        hTot_d   = hTot_q;
        hAct_d   = hAct_q;
        vLine    = vCnt_q;
        vaLine   = vaCnt_q;
        vTot_d   = vTot_q;
        vAct_d   = vAct_q;
        if (hsLead) begin
            hTot_d   = hCnt_q;
            hAct_d   = haCnt_q;
            hCnt_d   = H_ONE;
            haCnt_d  = {{(HSZ-1){1'b0}}, de1_q};
            lineDe_d = de1_q;
            vLine    = (vCnt_q == V_MAX) ? vCnt_q : vCnt_q + V_ONE;
            vaLine   = (lineDe_q && vaCnt_q != V_MAX) ? vaCnt_q + V_ONE : vaCnt_q;
            if (!hHave_q) begin
                hFirst_d = hCnt_q;
                hHave_d  = 1'b1;
            end else if (hCnt_q != hFirst_q) begin
                hMis_d = 1'b1;
            end
        end
        lineMis = hMis_d;
        vCnt_d  = vLine;
        vaCnt_d = vaLine;
        if (vsLead) begin
            vTot_d  = vLine;
            vAct_d  = vaLine;
            vCnt_d  = '0;
            vaCnt_d = '0;
            hHave_d = 1'b0;
            hMis_d  = 1'b0;
        end
    end

    assign geomNow = {hTot_d, hAct_d, vLine, vaLine};
    assign frameOk = (geomNow == snap_q) && !lineMis && !snapMis_q;

    // Lock FSM next state; a snapshot taken from an unstable frame never matches
    always_comb begin
        state_d  = state_q;
        snapLoad = 1'b0;
        if (vsLead) begin
            unique case (state_q)
                SEARCH:  state_d = MEASURE;
                MEASURE: begin
                    state_d  = VERIFY;
                    snapLoad = 1'b1;
                end
                VERIFY: begin
                    if (frameOk) state_d = LOCKED;
                    else         snapLoad = 1'b1;
                end
                LOCKED: begin
                    if (!frameOk) begin
                        state_d  = VERIFY;
                        snapLoad = 1'b1;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end else if (vCnt_q == V_MAX) begin
            state_d = SEARCH;
        end
    end

    // Measurement counters, published results, snapshot and FSM state
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            hCnt_q <= '0; haCnt_q <= '0; hFirst_q <= '0;
            hTot_q <= '0; hAct_q  <= '0;
            vCnt_q <= '0; vaCnt_q <= '0;
            vTot_q <= '0; vAct_q  <= '0;
            lineDe_q <= 1'b0; hHave_q <= 1'b0; hMis_q <= 1'b0;
            state_q  <= SEARCH;
            snap_q   <= '0;
            snapMis_q <= 1'b0;
        end else begin
            hCnt_q <= hCnt_d; haCnt_q <= haCnt_d; hFirst_q <= hFirst_d;
            hTot_q <= hTot_d; hAct_q  <= hAct_d;
            vCnt_q <= vCnt_d; vaCnt_q <= vaCnt_d;
            vTot_q <= vTot_d; vAct_q  <= vAct_d;
            lineDe_q <= lineDe_d; hHave_q <= hHave_d; hMis_q <= hMis_d;
            state_q  <= state_d;
            if (snapLoad) begin
                snap_q    <= geomNow;
                snapMis_q <= lineMis;
            end
        end
    end

    assign o_pix_valid   = pixValid_q;
    assign o_pix         = pix_q;
    assign o_x           = x_q;
    assign o_y           = y_q;
    assign o_line_start  = lineStart_q;
    assign o_frame_start = frameStart_q;
    assign o_h_total     = hTot_q;
    assign o_h_active    = hAct_q;
    assign o_v_total     = vTot_q;
    assign o_v_active    = vAct_q;
    assign o_locked      = (state_q == LOCKED);

`ifdef VGA_RX_FRAME_CRC_EN
    logic [15:0] crcAcc_q, crcOut_q;

    function automatic logic [15:0] crcStep(input logic [15:0] crc, input logic [11:0] pix);
        logic [15:0] c;
        logic [15:0] d;
        logic        fb;
        c = crc;
        d = {4'h0, pix};
        for (int i = 15; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    // CRC-16-CCITT over active pixels, latched and re-seeded at each frame start
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            crcAcc_q <= 16'hFFFF;
            crcOut_q <= '0;
        end else if (vsLead) begin
            crcOut_q <= crcAcc_q;
            crcAcc_q <= de1_q ? crcStep(16'hFFFF, rgb1_q) : 16'hFFFF;
        end else if (de1_q) begin
            crcAcc_q <= crcStep(crcAcc_q, rgb1_q);
        end
    end

    assign o_frame_crc = crcOut_q;
`endif

endmodule

// File: doc/vga_timing_rx.md
Name: vga_timing_rx

Overview:
- Receive side of the VGA timing interface: consumes hsync/vsync/de/12-bit RGB, as produced by the vga_core plus char_gen path, on the pixel clock.
- Recovers per-pixel X/Y coordinates and measures line/frame geometry.
- Declares lock once two consecutive frames have identical geometry.
- Used for loopback self-test of the video pipeline and as the front end of a future capture path.

Parameters:
- HSZ, 10, width of X coordinate and horizontal measurements.
- VSZ, 10, width of Y coordinate and vertical measurements.
- HS_POL, 0, hsync active level (0 = active-low, as in 640x480).
- VS_POL, 0, vsync active level.

Ports:
- clk_i  in  1  pixel clock
- rstn_i  in  1  asynchronous active-low reset
- i_hsync  in  1  horizontal sync
- i_vsync  in  1  vertical sync
- i_de  in  1  data enable (active video)
- i_rgb  in  12  pixel {R[11:8],G[7:4],B[3:0]}
- o_pix_valid  out  1  registered de
- o_pix  out  12  registered pixel
- o_x  out  HSZ  column of o_pix
- o_y  out  VSZ  row of o_pix
- o_line_start  out  1  one-cycle pulse on hsync leading edge
- o_frame_start  out  1  one-cycle pulse on vsync leading edge
- o_h_total, o_h_active  out  HSZ  last measured clocks/line, de clocks/line
- o_v_total, o_v_active  out  VSZ  last measured lines/frame, active lines/frame
- o_locked  out  1  geometry stable

Behaviour:
- Reset: all outputs 0; FSM in SEARCH.
- Inputs are registered once (same clock domain, no synchronizer).
- Edges are detected against a second register stage.
- A leading edge is a transition into the active level defined by HS_POL/VS_POL.
- Pixel path: o_pix_valid, o_pix, o_x and o_y appear 2 cycles after the corresponding input.
- X counting:
  - o_x is 0 on the first de cycle of a line.
  - o_x increments each subsequent de cycle.
  - o_x saturates at all-ones.
- Y counting:
  - o_y is 0 on the first active line after a vsync leading edge.
  - o_y increments on each de falling edge.
  - o_y saturates at all-ones.
- Measurement counters, each saturating (no wrap):
  - h_cnt: clocks between hsync leading edges.
  - ha_cnt: de clocks within the line.
  - v_cnt: hsync leading edges between vsync leading edges.
  - va_cnt: lines containing at least one de cycle.
- Horizontal results: o_h_total and o_h_active update at each hsync leading edge.
- Vertical results: o_v_total and o_v_active update at each vsync leading edge.
- FSM, with all transitions evaluated at vsync leading edges:
  - SEARCH: first edge -> MEASURE; counters cleared.
  - MEASURE: edge -> VERIFY; snapshot {h_total, h_active, v_total, v_active} stored.
  - VERIFY: edge with frame equal to snapshot -> LOCKED. Edge with mismatch -> stays in VERIFY; snapshot replaced.
  - LOCKED: edge with mismatch -> VERIFY; snapshot replaced. o_locked=1 only in LOCKED.
  - Any state: v_cnt reaching all-ones (no vsync) -> SEARCH, o_locked=0.
- Horizontal stability rule: within a frame, any line whose h_total differs from the first line's h_total marks the frame mismatched.
- Simultaneous hsync and vsync leading edges: line processing first, then frame processing, in the same cycle; o_line_start and o_frame_start both pulse.
- de asserted outside hsync/vsync blanking is accepted without checks.
- Reset mid-frame: immediate return to SEARCH; first lock requires 3 vsync edges after reset release.

Optional Feature:
- Macro: VGA_RX_FRAME_CRC_EN.
- When defined:
  - Adds output o_frame_crc [15:0].
  - CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first) accumulates over every active 12-bit pixel, zero-extended to 16 bits, one pixel per clock.
  - The value is latched to o_frame_crc at the vsync leading edge, then the accumulator re-inits.
  - o_frame_crc resets to 0.
- When undefined: port and logic absent; all other behaviour identical.

Test Plan:
- 640x480 standard timing (800x525, HS/VS active-low) for 4 frames -> o_h_total=800, o_h_active=640, o_v_total=525, o_v_active=480; o_locked rises at 3rd vsync edge and stays 1.
- Pixel path with i_rgb = {x[3:0], y[3:0], 4'hA} -> o_pix matches o_x/o_y for all pixels, 2-cycle latency; last pixel o_x=639, o_y=479.
- Locked, then one frame with a line of 801 clocks -> o_locked drops at that frame's vsync edge; re-locks after 2 more clean frames.
- vsync held inactive for 1024 lines -> FSM to SEARCH, o_locked=0, no spurious o_frame_start.
- rstn_i pulsed low mid-frame -> all outputs 0 asynchronously; lock returns at 3rd subsequent vsync edge.
- VGA_RX_FRAME_CRC_EN with constant pixel 0x000 frames -> identical o_frame_crc every frame. Flipping one pixel -> different value that frame only.
